// File: rtl/mbox_req_seq.sv
// mbox_req_seq: EBOX memory request sequencer feeding the MBOX (VMA is PDP-10 bits 13:35, data bits 0:35, MSB first).
// Define MBOX_RPW_EN to add the read-pause-write (RPW) state; without it rpwPending is tied low.
module mbox_req_seq #(
    parameter int READ_LATENCY = 1
) (
    input  logic        mboxClk,
    input  logic        mboxReset,
    input  logic        eboxReq,
    input  logic        eboxRead,
    input  logic        eboxWrite,
    input  logic        eboxPSE,
    input  logic [22:0] eboxVMA,
    input  logic [35:0] eboxWriteData,
    input  logic [35:0] cacheDataRead,
    output logic        eboxBusy,
    output logic        memAck,
    output logic [35:0] mbr,
    output logic        mboxReq,
    output logic        mboxRead,
    output logic        mboxWrite,
    output logic        mboxPSE,
    output logic [22:0] mboxVMA,
    output logic [35:0] mboxWriteData,
    output logic        rpwPending,
    output logic        protoErr
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
`ifdef MBOX_RPW_EN
        , RPW
`endif
    } state_t;

    state_t     state, nstate;
    logic       op_wr, pse_q, accept, can_take, op_ok, rpw_gate;
    logic [3:0] cnt;

`ifdef MBOX_RPW_EN
    // The DONE cycle of a PSE read already obeys the paused-write rules.
    assign rpw_gate = state == RPW || (state == DONE && !op_wr && pse_q);
    assign can_take = state == IDLE || state == DONE || state == RPW;
`else
    assign rpw_gate = 1'b0;
    assign can_take = state == IDLE || state == DONE;
`endif
    assign op_ok  = eboxRead ^ eboxWrite;
    assign accept = eboxReq && can_take &&
                    (rpw_gate ? eboxWrite && !eboxRead && eboxVMA == mboxVMA : op_ok);

    always_ff @(posedge mboxClk) begin
        if (mboxReset)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = accept ? ISSUE : IDLE;
            ISSUE:   nstate = op_wr ? DONE : WAIT;
            WAIT:    nstate = cnt == 4'd0 ? DONE : WAIT;
`ifdef MBOX_RPW_EN
            DONE:    nstate = accept ? ISSUE : rpw_gate ? RPW : IDLE;
            RPW:     nstate = accept ? ISSUE : RPW;
`else
            DONE:    nstate = accept ? ISSUE : IDLE;
`endif
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        eboxBusy  = state == ISSUE || state == WAIT;
        memAck    = state == DONE;
        mboxReq   = state == ISSUE;
        mboxRead  = state == ISSUE && !op_wr;
        mboxWrite = state == ISSUE && op_wr;
        mboxPSE   = state == ISSUE && pse_q;
    end

    always_ff @(posedge mboxClk) begin
        if (mboxReset) begin
            op_wr         <= 1'b0;
            pse_q         <= 1'b0;
            cnt           <= 4'd0;
            mbr           <= 36'd0;
            mboxVMA       <= 23'd0;
            mboxWriteData <= 36'd0;
            protoErr      <= 1'b0;
        end else begin
            if (accept) begin
                op_wr         <= eboxWrite;
                pse_q         <= eboxPSE || rpw_gate;
                mboxVMA       <= eboxVMA;
                mboxWriteData <= eboxWriteData;
            end
            if (eboxReq && !accept)
                protoErr <= 1'b1;
            if (state == ISSUE)
                cnt <= 4'(READ_LATENCY - 1);
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd0)
                mbr <= cacheDataRead;
        end
    end

`ifdef MBOX_RPW_EN
    always_ff @(posedge mboxClk) begin
        if (mboxReset)
            rpwPending <= 1'b0;
        else if (state == DONE && rpw_gate)
            rpwPending <= 1'b1;
        else if (state == DONE && op_wr)
            rpwPending <= 1'b0;
    end
`else
    assign rpwPending = 1'b0;
`endif
endmodule

// File: tb/tb_mbox_req_seq.sv
// tb_mbox_req_seq: two sequencers (READ_LATENCY 1 and 4) driven by directed and random transactions,
// each with its own MBOX memory model; expectations come from a transaction-level reference.
module tb_mbox_req_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req, erd, ewr, epse;
    logic [1:0][22:0] evma, mvma;
    logic [1:0][35:0] ewd, mbr, mwd;
    logic [1:0]       busy, ack, mreq, mrd, mwr, mpse, rpwp, perr;

    int tests = 0;
    int fails = 0;
    logic [1:0]       exp_perr, exp_rpw;
    logic [1:0][35:0] exp_mbr;
    logic [35:0]      rmem [logic [23:0]];

    function automatic int lat(int u);
        return u == 0 ? 1 : 4;
    endfunction

    function automatic logic [35:0] init_val(logic [22:0] a);
        return a == 23'o1234 ? 36'o123456654321 : {13'h0abc, a} ^ 36'o525252525252;
    endfunction

    function automatic logic [35:0] ref_rd(int u, logic [22:0] a);
        logic [23:0] k;
        k = {u[0], a};
        return rmem.exists(k) ? rmem[k] : init_val(a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_u
        logic [35:0] cdr;
        logic [35:0] emem [logic [22:0]];
        int          cyc, due;
        logic [22:0] raddr;

        mbox_req_seq #(.READ_LATENCY(g == 0 ? 1 : 4)) dut (
            .mboxClk(clk), .mboxReset(rst), .eboxReq(req[g]), .eboxRead(erd[g]),
            .eboxWrite(ewr[g]), .eboxPSE(epse[g]), .eboxVMA(evma[g]),
            .eboxWriteData(ewd[g]), .cacheDataRead(cdr), .eboxBusy(busy[g]),
            .memAck(ack[g]), .mbr(mbr[g]), .mboxReq(mreq[g]), .mboxRead(mrd[g]),
            .mboxWrite(mwr[g]), .mboxPSE(mpse[g]), .mboxVMA(mvma[g]),
            .mboxWriteData(mwd[g]), .rpwPending(rpwp[g]), .protoErr(perr[g])
        );

        // MBOX model: read data is valid only in cycle issue+latency, junk otherwise.
        initial begin
            cyc   = 0;
            due   = -1;
            raddr = '0;
            cdr   = '0;
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                if (mreq[g] && mrd[g]) begin
                    due   = cyc + lat(g);
                    raddr = mvma[g];
                end
                if (mreq[g] && mwr[g])
                    emem[mvma[g]] = mwd[g];
                cdr = (cyc == due) ? (emem.exists(raddr) ? emem[raddr] : init_val(raddr))
                                   : {4'($urandom), $urandom};
            end
        end
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int u, input string t);
        chk($sformatf("u%0d.%s.busy", u, t), busy[u], 0);
        chk($sformatf("u%0d.%s.ack", u, t), ack[u], 0);
        chk($sformatf("u%0d.%s.strobes", u, t), {mreq[u], mrd[u], mwr[u], mpse[u]}, 0);
        chk($sformatf("u%0d.%s.mbr", u, t), mbr[u], exp_mbr[u]);
        chk($sformatf("u%0d.%s.perr", u, t), perr[u], exp_perr[u]);
        chk($sformatf("u%0d.%s.rpw", u, t), rpwp[u], exp_rpw[u]);
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b1;
        req  = '1;
        erd  = 2'($urandom);
        ewr  = 2'($urandom);
        evma = {23'($urandom), 23'($urandom)};
        for (int i = 0; i < n; i++) begin
            step();
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("u%0d.rst.flags", u),
                    {busy[u], ack[u], mreq[u], mrd[u], mwr[u], mpse[u], rpwp[u], perr[u]}, 0);
                chk($sformatf("u%0d.rst.mbr", u), mbr[u], 0);
                chk($sformatf("u%0d.rst.vma", u), mvma[u], 0);
                chk($sformatf("u%0d.rst.wd", u), mwd[u], 0);
            end
        end
        rst      = 1'b0;
        req      = '0;
        exp_perr = '0;
        exp_rpw  = '0;
        exp_mbr  = '0;
    endtask

    // Caller is in IDLE/DONE/RPW; returns positioned in the DONE cycle of this transaction.
    task automatic op(input int u, input bit w, input bit p, input logic [22:0] a,
                      input logic [35:0] d, input bit poke);
        logic [23:0] k;
        req[u]  = 1'b1;
        erd[u]  = !w;
        ewr[u]  = w;
        epse[u] = p;
        evma[u] = a;
        ewd[u]  = d;
        step();
        req[u]  = poke;
        erd[u]  = 1'($urandom);
        ewr[u]  = 1'($urandom);
        evma[u] = 23'($urandom);
        ewd[u]  = {4'($urandom), $urandom};
        chk($sformatf("u%0d.issue.strobes", u), {mreq[u], mrd[u], mwr[u], mpse[u]}, {1'b1, !w, w, p});
        chk($sformatf("u%0d.issue.vma", u), mvma[u], a);
        chk($sformatf("u%0d.issue.wd", u), mwd[u], d);
        chk($sformatf("u%0d.issue.busy_ack", u), {busy[u], ack[u]}, 2'b10);
        chk($sformatf("u%0d.issue.perr", u), perr[u], exp_perr[u]);
        if (poke)
            exp_perr[u] = 1'b1;
        for (int i = 0; i < (w ? 0 : lat(u)); i++) begin
            step();
            req[u] = 1'b0;
            chk($sformatf("u%0d.wait.busy_ack_req", u), {busy[u], ack[u], mreq[u]}, 3'b100);
            chk($sformatf("u%0d.wait.vma", u), mvma[u], a);
            chk($sformatf("u%0d.wait.perr", u), perr[u], exp_perr[u]);
        end
        step();
        req[u] = 1'b0;
        k = {u[0], a};
        if (w)
            rmem[k] = d;
        else
            exp_mbr[u] = ref_rd(u, a);
        chk($sformatf("u%0d.done.busy_ack_req", u), {busy[u], ack[u], mreq[u]}, 3'b010);
        chk($sformatf("u%0d.done.mbr", u), mbr[u], exp_mbr[u]);
        chk($sformatf("u%0d.done.vma", u), mvma[u], a);
        chk($sformatf("u%0d.done.perr", u), perr[u], exp_perr[u]);
        chk($sformatf("u%0d.done.rpw", u), rpwp[u], exp_rpw[u]);
    endtask

    task automatic illegal(input int u);
        bit both;
        both    = 1'($urandom);
        req[u]  = 1'b1;
        erd[u]  = both;
        ewr[u]  = both;
        evma[u] = 23'($urandom);
        step();
        req[u]      = 1'b0;
        exp_perr[u] = 1'b1;
        chk_idle(u, "illegal");
    endtask

    initial begin
        rst = 1'b1; req = '0; erd = '0; ewr = '0; epse = '0; evma = '0; ewd = '0;
        exp_perr = '0; exp_rpw = '0; exp_mbr = '0;
        do_reset(3);

        op(0, 0, 0, 23'o1234, 36'o0, 0);
        chk("u0.rd1234.mbr_const", mbr[0], 36'o123456654321);
        step();
        chk_idle(0, "after_rd");

        op(0, 1, 0, 23'o100, 36'o777000111222, 0);
        op(0, 0, 0, 23'o100, 36'o0, 0);
        chk("u0.wr_rd.mbr_const", mbr[0], 36'o777000111222);
        step();
        chk_idle(0, "after_wr_rd");

        op(1, 0, 0, 23'o2345, 36'o0, 1);
        step();
        chk_idle(1, "after_busy_poke");
        chk("u1.busy_poke.perr_const", perr[1], 1);

        illegal(0);
        step();
        chk("u0.illegal.no_req", mreq[0], 0);

        do_reset(1);
        req[1] = 1'b1; erd[1] = 1'b1; ewr[1] = 1'b0; evma[1] = 23'o3333;
        step();
        req[1] = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("u1.midrst.flags", {busy[1], ack[1], mreq[1]}, 0);
        chk("u1.midrst.mbr", mbr[1], 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("u1.midrst.no_ack", {ack[1], busy[1], mreq[1]}, 0);
        end

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 20; n++) begin
                bit          w, p;
                logic [22:0] a;
                w = 1'($urandom);
                a = 23'o100 + 23'($urandom_range(0, 7));
`ifdef MBOX_RPW_EN
                p = w ? 1'($urandom) : 1'b0;
`else
                p = 1'($urandom);
`endif
                op(u, w, p, a, {4'($urandom), $urandom}, $urandom_range(0, 3) == 0);
                case ($urandom_range(0, 2))
                    0: ;
                    1: begin step(); chk_idle(u, "gap"); end
                    default: illegal(u);
                endcase
            end
            step();
            chk_idle(u, "rand_end");
        end

`ifdef MBOX_RPW_EN
        do_reset(1);
        op(0, 0, 1, 23'o200, 36'o0, 0);
        step();
        exp_rpw[0] = 1'b1;
        chk_idle(0, "rpw_enter");
        req[0] = 1'b1; erd[0] = 1'b0; ewr[0] = 1'b1; evma[0] = 23'o201;
        step();
        req[0]      = 1'b0;
        exp_perr[0] = 1'b1;
        chk_idle(0, "rpw_badvma");
        step();
        chk_idle(0, "rpw_hold");
        op(0, 1, 1, 23'o200, 36'o444333222111, 0);
        step();
        exp_rpw[0] = 1'b0;
        chk_idle(0, "rpw_exit");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mbox_req_seq.md
Name: mbox_req_seq

Overview:
- EBOX-side memory request sequencer, directly upstream of the MBOX.
- Accepts one EBOX memory request at a time and registers the VMA and write data.
- Drives single-cycle req/read/write strobes into the MBOX, counts the MBOX read latency, and captures cacheDataRead into an MBR.
- Returns a one-cycle memAck to the EBOX; optionally supports PSE read-pause-write.

Parameters:
- READ_LATENCY, 1, cycles from the MBOX issue cycle until cacheDataRead is valid; legal range 1..15.

Ports:
- mboxClk  input  1  sole clock, rising edge.
- mboxReset  input  1  synchronous, active-high reset.
- eboxReq  input  1  request strobe, sampled when eboxBusy=0.
- eboxRead  input  1  read request.
- eboxWrite  input  1  write request.
- eboxPSE  input  1  pause/store-enable qualifier.
- eboxVMA  input  23  [13:35] virtual memory address.
- eboxWriteData  input  36  [0:35] store data.
- cacheDataRead  input  36  [0:35] MBOX read data.
- eboxBusy  output  1  sequencer cannot accept a request this cycle.
- memAck  output  1  one-cycle completion pulse.
- mbr  output  36  [0:35] captured read data.
- mboxReq  output  1  MBOX request strobe.
- mboxRead  output  1  MBOX read strobe.
- mboxWrite  output  1  MBOX write strobe.
- mboxPSE  output  1  PSE qualifier to the MBOX.
- mboxVMA  output  23  [13:35] registered address.
- mboxWriteData  output  36  [0:35] registered store data.
- rpwPending  output  1  read-pause-write in progress.
- protoErr  output  1  sticky protocol-violation flag.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, RPW.
- Reset: synchronous, active-high.
  - State returns to IDLE; any in-flight operation is abandoned with no memAck.
  - Latency counter cleared.
  - Every output is 0, including mbr, mboxVMA, mboxWriteData, protoErr, rpwPending.
- Accept: in IDLE or DONE, eboxReq=1 with exactly one of eboxRead/eboxWrite asserted.
  - eboxVMA, eboxWriteData, eboxPSE and the op are captured at that edge.
  - Next state is ISSUE.
  - eboxReq with both or neither of read/write: protoErr set, request ignored.
- eboxBusy: 1 in ISSUE and WAIT; 0 in IDLE, DONE and RPW.
  - eboxReq while eboxBusy=1: ignored, protoErr set.
- mboxVMA / mboxWriteData: update only on accept and hold otherwise.
- ISSUE (one cycle, call it T):
  - mboxReq=1; mboxRead or mboxWrite=1 per the captured op; mboxPSE=captured PSE.
  - Strobes are 0 in every other state.
  - Write: next state is DONE.
  - Read: 4-bit counter loaded with READ_LATENCY-1; next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At counter 0 (cycle T+READ_LATENCY), mbr <= cacheDataRead and the next state is DONE.
- DONE (cycle T+READ_LATENCY+1 for a read, T+1 for a write):
  - memAck=1, mbr is valid; writes leave mbr unchanged.
  - Next state: ISSUE if a new request is accepted this cycle, else IDLE (or RPW, see Optional Feature).
- Read-to-read throughput: one request per READ_LATENCY+2 cycles.
- protoErr: cleared only by reset.

Optional Feature:
- Macro: MBOX_RPW_EN.
- Defined:
  - A read with PSE=1 goes DONE->RPW and sets rpwPending=1.
  - In RPW, only a write to the identical VMA is accepted. It goes through ISSUE with mboxWrite=1 and mboxPSE=1; its DONE clears rpwPending and returns to IDLE.
  - In RPW, a read, or a write to a different VMA: ignored, protoErr set, rpwPending held.
  - Reset clears rpwPending.
- Undefined:
  - The RPW state is absent and rpwPending is tied to 0.
  - eboxPSE is passed through to mboxPSE during ISSUE only, with no pause.

Test Plan:
- Reset/idle: assert mboxReset 3 cycles with eboxReq=1 -> all outputs 0; no mboxReq.
- Read, READ_LATENCY=1: read VMA 0o1234 with the model returning 0o123456654321 -> mboxReq/mboxRead one cycle after accept; memAck 2 cycles after ISSUE; mbr=0o123456654321.
- Write then read: write 0o777000111222 to VMA 0o100, then read VMA 0o100 issued in the write's DONE cycle -> mboxWrite one cycle; read accepted with no idle gap; mbr=0o777000111222.
- Latency and busy, READ_LATENCY=4: read, with a second eboxReq while busy -> memAck exactly 5 cycles after ISSUE; second request dropped; protoErr=1.
- Illegal request: eboxRead=eboxWrite=1 in IDLE -> no strobe; protoErr=1.
- Mid-op reset: mboxReset in WAIT -> no memAck, mbr=0, IDLE next cycle.
- RPW (MBOX_RPW_EN): PSE read of VMA 0o200 -> rpwPending=1.
  - A write to 0o201 -> protoErr=1, no strobe.
  - A write to 0o200 -> mboxWrite with mboxPSE=1; rpwPending=0 after its memAck.
